// File: rtl/bus_write_decoder.sv
// Bus write decoder: turns a held write request into one-hot destination load enables, with an optional HI/LO pair write.
// Optional build macro BUSWR_PROTECT_R0_EN makes single writes to R0 illegal.
`timescale 1ns/1ps
module bus_write_decoder (
   input  logic        clock,
   input  logic        clear,
   input  logic [31:0] BusMuxOut,
   input  logic [4:0]  dest_code,
   input  logic        wr_req,
   input  logic        wr_pair,
   input  logic [31:0] pair_hi,
   input  logic [31:0] pair_lo,
   output logic [23:0] reg_in,
   output logic [31:0] dest_data,
   output logic        wr_ack,
   output logic        busy,
   output logic        err_illegal
);

   typedef enum logic [2:0] {IDLE, WRITE, PAIR_HI, PAIR_LO, ERR} state_t;

   localparam int unsigned HI_CODE = 16;
   localparam int unsigned LO_CODE = 17;

   state_t      state;
   logic [31:0] lo_word;
   logic        illegal;

   // Codes 24-31 have no destination; pair writes ignore dest_code entirely.
   always_comb begin
      illegal = 1'b0;
      if (!wr_pair) begin
         illegal = (dest_code[4:3] == 2'b11);
`ifdef BUSWR_PROTECT_R0_EN
         if (dest_code == 5'd0)
            illegal = 1'b1;
`else
`endif
      end
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         state       <= IDLE;
         lo_word     <= '0;
         reg_in      <= '0;
         dest_data   <= '0;
         wr_ack      <= 1'b0;
         busy        <= 1'b0;
         err_illegal <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               reg_in      <= '0;
               wr_ack      <= 1'b0;
               err_illegal <= 1'b0;
               busy        <= 1'b0;
               if (wr_req) begin
                  busy    <= 1'b1;
                  lo_word <= pair_lo;
                  if (wr_pair) begin
                     state     <= PAIR_HI;
                     reg_in    <= 24'(1) << HI_CODE;
                     dest_data <= pair_hi;
                  end else if (illegal) begin
                     state       <= ERR;
                     wr_ack      <= 1'b1;
                     err_illegal <= 1'b1;
                  end else begin
                     state     <= WRITE;
                     reg_in    <= 24'(1) << dest_code;
                     dest_data <= BusMuxOut;
                     wr_ack    <= 1'b1;
                  end
               end
            end
            PAIR_HI: begin
               state     <= PAIR_LO;
               reg_in    <= 24'(1) << LO_CODE;
               dest_data <= lo_word;
               wr_ack    <= 1'b1;
               busy      <= 1'b1;
            end
            default: begin
               // WRITE, PAIR_LO and ERR all last one cycle and return to IDLE.
               state       <= IDLE;
               reg_in      <= '0;
               wr_ack      <= 1'b0;
               err_illegal <= 1'b0;
               busy        <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bus_write_decoder.sv
// Table-driven bench for bus_write_decoder; each row is one cycle of inputs and the outputs expected after that edge.
`timescale 1ns/1ps
module tb_bus_write_decoder;

   logic        clock = 1'b0;
   logic        clear;
   logic [31:0] BusMuxOut;
   logic [4:0]  dest_code;
   logic        wr_req;
   logic        wr_pair;
   logic [31:0] pair_hi;
   logic [31:0] pair_lo;
   logic [23:0] reg_in;
   logic [31:0] dest_data;
   logic        wr_ack;
   logic        busy;
   logic        err_illegal;

   bus_write_decoder dut (
      .clock(clock), .clear(clear), .BusMuxOut(BusMuxOut), .dest_code(dest_code),
      .wr_req(wr_req), .wr_pair(wr_pair), .pair_hi(pair_hi), .pair_lo(pair_lo),
      .reg_in(reg_in), .dest_data(dest_data), .wr_ack(wr_ack), .busy(busy),
      .err_illegal(err_illegal)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic        clr;
      logic        req;
      logic        pair;
      logic [4:0]  dest;
      logic [31:0] bus;
      logic [31:0] hi;
      logic [31:0] lo;
   } vin_t;

   typedef struct packed {
      logic [23:0] ri;
      logic [31:0] data;
      logic        ack;
      logic        bsy;
      logic        err;
   } vout_t;

   typedef struct {
      vin_t  i;
      vout_t o;
   } vec_t;

   vec_t  tbl[$];
   vout_t sb[$];
   int    passed = 0;
   int    total  = 0;

   task automatic add(input logic c, input logic r, input logic p, input logic [4:0] d,
                      input logic [31:0] b, input logic [31:0] h, input logic [31:0] l,
                      input logic [23:0] ri, input logic [31:0] dd,
                      input logic a, input logic bs, input logic e);
      vec_t v;
      v.i = '{clr: c, req: r, pair: p, dest: d, bus: b, hi: h, lo: l};
      v.o = '{ri: ri, data: dd, ack: a, bsy: bs, err: e};
      tbl.push_back(v);
   endtask

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got === want) passed++;
      else $display("FAIL %s: got %h, want %h", name, got, want);
   endtask

   initial begin
      vout_t got, exp;
      int    pulses20 = 0;
      clear = 1'b1; wr_req = 1'b0; wr_pair = 1'b0; dest_code = '0;
      BusMuxOut = '0; pair_hi = '0; pair_lo = '0;

      //   clr req pair dest bus           hi            lo            reg_in       data          ack bsy err
      add(1, 0, 0, 5'd0,  32'h0,        32'h0,        32'h0,        24'h000000, 32'h00000000, 0, 0, 0); // 0 reset
      add(0, 1, 0, 5'd5,  32'hDEADBEEF, 32'h0,        32'h0,        24'h000020, 32'hDEADBEEF, 1, 1, 0); // 1 single write
      add(0, 0, 0, 5'd5,  32'h0,        32'h0,        32'h0,        24'h000000, 32'hDEADBEEF, 0, 0, 0); // 2
      add(0, 1, 1, 5'd27, 32'h99,       32'h1,        32'h2,        24'h010000, 32'h00000001, 0, 1, 0); // 3 pair hi
      add(0, 0, 0, 5'd0,  32'h0,        32'h55,       32'h66,       24'h020000, 32'h00000002, 1, 1, 0); // 4 pair lo
      add(0, 0, 0, 5'd0,  32'h0,        32'h0,        32'h0,        24'h000000, 32'h00000002, 0, 0, 0); // 5
      add(0, 1, 0, 5'd27, 32'h1234,     32'h0,        32'h0,        24'h000000, 32'h00000002, 1, 1, 1); // 6 illegal
      add(0, 0, 0, 5'd0,  32'h0,        32'h0,        32'h0,        24'h000000, 32'h00000002, 0, 0, 0); // 7
      add(0, 1, 0, 5'd31, 32'h4321,     32'h0,        32'h0,        24'h000000, 32'h00000002, 1, 1, 1); // 8 top code
      add(0, 0, 0, 5'd0,  32'h0,        32'h0,        32'h0,        24'h000000, 32'h00000002, 0, 0, 0); // 9
      add(0, 1, 0, 5'd23, 32'hCAFE,     32'h0,        32'h0,        24'h800000, 32'h0000CAFE, 1, 1, 0); // 10 last legal
      add(0, 0, 0, 5'd0,  32'h0,        32'h0,        32'h0,        24'h000000, 32'h0000CAFE, 0, 0, 0); // 11
      add(0, 1, 0, 5'd24, 32'h0,        32'h0,        32'h0,        24'h000000, 32'h0000CAFE, 1, 1, 1); // 12 first illegal
      add(0, 0, 0, 5'd0,  32'h0,        32'h0,        32'h0,        24'h000000, 32'h0000CAFE, 0, 0, 0); // 13
      add(0, 1, 0, 5'd20, 32'hA5,       32'h0,        32'h0,        24'h100000, 32'h000000A5, 1, 1, 0); // 14 held req
      add(0, 1, 0, 5'd20, 32'hA5,       32'h0,        32'h0,        24'h000000, 32'h000000A5, 0, 0, 0); // 15 ignored while busy
      add(0, 1, 0, 5'd20, 32'hA5,       32'h0,        32'h0,        24'h100000, 32'h000000A5, 1, 1, 0); // 16 resampled
      add(0, 1, 0, 5'd20, 32'hA5,       32'h0,        32'h0,        24'h000000, 32'h000000A5, 0, 0, 0); // 17
      add(0, 0, 0, 5'd0,  32'h0,        32'h0,        32'h0,        24'h000000, 32'h000000A5, 0, 0, 0); // 18
      add(0, 1, 1, 5'd3,  32'h0,        32'h11,       32'h22,       24'h010000, 32'h00000011, 0, 1, 0); // 19 pair hi
      add(1, 0, 0, 5'd0,  32'h0,        32'h0,        32'h0,        24'h000000, 32'h00000000, 0, 0, 0); // 20 clear mid-pair
      add(0, 0, 0, 5'd0,  32'h0,        32'h0,        32'h0,        24'h000000, 32'h00000000, 0, 0, 0); // 21 no late ack
      add(0, 1, 0, 5'd9,  32'h31,       32'h0,        32'h0,        24'h000200, 32'h00000031, 1, 1, 0); // 22
      add(1, 1, 0, 5'd7,  32'h77,       32'h0,        32'h0,        24'h000000, 32'h00000000, 0, 0, 0); // 23 clear wins
`ifdef BUSWR_PROTECT_R0_EN
      add(0, 1, 0, 5'd0,  32'h88,       32'h0,        32'h0,        24'h000000, 32'h00000000, 1, 1, 1); // 24 R0 blocked
      add(0, 0, 0, 5'd0,  32'h0,        32'h0,        32'h0,        24'h000000, 32'h00000000, 0, 0, 0); // 25
      add(0, 1, 1, 5'd0,  32'h0,        32'h3,        32'h4,        24'h010000, 32'h00000003, 0, 1, 0); // 26 pair still ok
`else
      add(0, 1, 0, 5'd0,  32'h88,       32'h0,        32'h0,        24'h000001, 32'h00000088, 1, 1, 0); // 24 R0 write
      add(0, 0, 0, 5'd0,  32'h0,        32'h0,        32'h0,        24'h000000, 32'h00000088, 0, 0, 0); // 25
      add(0, 1, 1, 5'd0,  32'h0,        32'h3,        32'h4,        24'h010000, 32'h00000003, 0, 1, 0); // 26
`endif
      add(0, 0, 0, 5'd0,  32'h0,        32'h0,        32'h0,        24'h020000, 32'h00000004, 1, 1, 0); // 27
      add(0, 0, 0, 5'd0,  32'h0,        32'h0,        32'h0,        24'h000000, 32'h00000004, 0, 0, 0); // 28

      foreach (tbl[n]) begin
         @(negedge clock);
         clear = tbl[n].i.clr;  wr_req = tbl[n].i.req;  wr_pair = tbl[n].i.pair;
         dest_code = tbl[n].i.dest; BusMuxOut = tbl[n].i.bus;
         pair_hi = tbl[n].i.hi; pair_lo = tbl[n].i.lo;
         sb.push_back(tbl[n].o);
         @(posedge clock);
         #1;
         got = '{ri: reg_in, data: dest_data, ack: wr_ack, bsy: busy, err: err_illegal};
         if (sb.size() == 0) begin
            total++;
            $display("FAIL scoreboard_empty row%0d: got none, want one entry", n);
         end else begin
            exp = sb.pop_front();
            check($sformatf("row%0d_reg_in", n), 64'(got.ri), 64'(exp.ri));
            check($sformatf("row%0d_dest_data", n), 64'(got.data), 64'(exp.data));
            check($sformatf("row%0d_ack_busy_err", n), 64'({got.ack, got.bsy, got.err}),
                  64'({exp.ack, exp.bsy, exp.err}));
         end
         if (n >= 14 && n <= 18 && reg_in[20]) pulses20++;
         check($sformatf("row%0d_onehot", n), 64'($countones(reg_in) <= 1), 64'(1));
      end

      check("held_req_r20_pulses", 64'(pulses20), 64'(2));
      check("scoreboard_drained", 64'(sb.size()), 64'(0));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/bus_write_decoder.md
BUS_WRITE_DECODER -- requirements
Module: bus_write_decoder

Interface
REQ-001 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port clear, input, 1, reset that is synchronous and active-high.
REQ-003 SHALL have port BusMuxOut, input, 32, bus data to be written.
REQ-004 SHALL have port dest_code, input, 5, destination select using the same 0..23 numbering as the bus source codes: 0-15 = R0-R15, 16 = HI, 17 = LO, 18 = RZ_HI, 19 = RZ_LO, 20 = PC, 21 = MDR, 22 = Outport, 23 = C.
REQ-005 SHALL have port wr_req, input, 1, write request, held high by the requester until wr_ack.
REQ-006 SHALL have port wr_pair, input, 1, sampled with wr_req; requests a 64-bit HI/LO pair write.
REQ-007 SHALL have port pair_hi, input, 32, upper word for a pair write.
REQ-008 SHALL have port pair_lo, input, 32, lower word for a pair write.
REQ-009 SHALL have port reg_in, output, 24, one-hot destination load enables; bit n loads destination code n.
REQ-010 SHALL have port dest_data, output, 32, registered data presented to destinations.
REQ-011 SHALL have port wr_ack, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-013 SHALL have port err_illegal, output, 1, one-cycle pulse marking a rejected request.

Function
REQ-014 SHALL implement states IDLE, WRITE, PAIR_HI, PAIR_LO and ERR.
REQ-015 SHALL, in IDLE with wr_req=1, capture dest_code, BusMuxOut, pair_hi and pair_lo at that edge.
REQ-016 SHALL treat dest_code 24-31 as illegal; next state is ERR.
REQ-017 SHALL, for a legal request with wr_pair=0, go to WRITE, with reg_in[dest_code]=1 and dest_data=captured BusMuxOut.
REQ-018 SHALL, for wr_pair=1, ignore dest_code and go to PAIR_HI: reg_in[16]=1, dest_data=pair_hi; then PAIR_LO: reg_in[17]=1, dest_data=pair_lo.
REQ-019 SHALL hold WRITE, PAIR_HI, PAIR_LO and ERR for exactly one cycle each; next state after WRITE, PAIR_LO and ERR is IDLE.
REQ-020 SHALL assert wr_ack in WRITE, in PAIR_LO and in ERR (with err_illegal=1 in ERR), so every request is acknowledged exactly once.
REQ-021 SHALL give a latency of 1 cycle (single write) or 2 cycles (pair write) from the sampling edge to wr_ack.
REQ-022 SHALL keep reg_in all-zero in IDLE and ERR; at most one bit of reg_in is ever high.
REQ-023 SHALL ignore wr_req while busy=1; a request held high after its wr_ack cycle is resampled in IDLE as a new request.
REQ-024 SHALL hold dest_data at its last value when no write is in progress.

Reset
REQ-025 SHALL, on clear=1 at a clock edge, enter IDLE with reg_in=0, dest_data=0, wr_ack=0, busy=0 and err_illegal=0.
REQ-026 SHALL give clear priority over wr_req.
REQ-027 SHALL, on clear during PAIR_HI, abort the operation: PAIR_LO enable is not issued and no wr_ack is given.

Configuration
REQ-028 SHALL, with macro BUSWR_PROTECT_R0_EN defined, treat dest_code 0 with wr_pair=0 as illegal (ERR path, reg_in[0] never asserted).
REQ-029 SHALL, with BUSWR_PROTECT_R0_EN undefined, treat code 0 as a normal R0 write.

Verification
REQ-030 SHALL cover single write: dest_code=5, BusMuxOut=0xDEADBEEF, wr_req pulse -> next cycle reg_in=0x000020, dest_data=0xDEADBEEF, wr_ack=1, busy=1.
REQ-031 SHALL cover pair write: wr_pair=1, pair_hi=0x1, pair_lo=0x2 -> cycle 1 reg_in=0x010000 and dest_data=0x1; cycle 2 reg_in=0x020000, dest_data=0x2, wr_ack=1.
REQ-032 SHALL cover illegal code: dest_code=27 -> next cycle reg_in=0, err_illegal=1, wr_ack=1, dest_data unchanged.
REQ-033 SHALL cover mid-pair reset: clear=1 in the PAIR_HI cycle -> following cycle IDLE, reg_in=0, no wr_ack, busy=0.
REQ-034 SHALL cover held request: wr_req held high with dest_code=20 for 4 cycles -> reg_in[20] pulses exactly twice, on alternate cycles.
REQ-035 SHALL cover R0 write: dest_code=0 -> reg_in=0x000001 without BUSWR_PROTECT_R0_EN; err_illegal=1 and reg_in=0 with the macro defined.
